// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master PicoRV32 memory-bus arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    localparam int TO_W = 16;

    // One master's request bundle, so the owned path is muxed once.
    typedef struct packed {
        logic        valid;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

endpackage

// File: rtl/mem_arb_timeout.sv
// Watchdog for a granted transaction: counts stalled cycles and flags expiry.
module mem_arb_timeout
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic resetn,
    input  logic active,
    input  logic s_ready,
    output logic expired
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] count;

    // Clearing while not active means every grant starts from zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (!active) begin
            count <= '0;
        end else if (!s_ready) begin
            count <= count + 1'b1;
        end
    end

    assign expired = active && !s_ready && (count == LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the PicoRV32 native memory bus.
// Optional watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    output logic [1:0]  grant,
    output logic        timeout_err
);

    state_t state, state_nxt;
    logic   last, last_nxt;     // 1 = m1 was served last, so m0 wins the next tie
    logic   expired;
    logic   to_hit;

    req_t   m0_req, m1_req, own_req;
    logic   owner;              // 0 = m0, 1 = m1; meaningful only in OWNx
    logic   own_ready;
    logic [31:0] own_rdata;

    assign m0_req  = '{valid: m0_valid, instr: m0_instr, addr: m0_addr,
                       wdata: m0_wdata, wstrb: m0_wstrb};
    assign m1_req  = '{valid: m1_valid, instr: m1_instr, addr: m1_addr,
                       wdata: m1_wdata, wstrb: m1_wstrb};
    assign owner   = (state == OWN1);
    assign own_req = owner ? m1_req : m0_req;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    // NOTE: every output of this block is defaulted first so no latch can be inferred.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        s_valid   = 1'b0;
        s_instr   = 1'b0;
        s_addr    = '0;
        s_wdata   = '0;
        s_wstrb   = '0;
        own_ready = 1'b0;
        own_rdata = '0;
        to_hit    = 1'b0;
        grant     = GRANT_NONE;

        unique case (state)
            IDLE: begin
                if (m0_valid && m1_valid) begin
                    state_nxt = last ? OWN0 : OWN1;
                end else if (m0_valid) begin
                    state_nxt = OWN0;
                end else if (m1_valid) begin
                    state_nxt = OWN1;
                end
            end

            OWN0, OWN1: begin
                grant     = owner ? GRANT_M1 : GRANT_M0;
                s_valid   = own_req.valid;
                s_instr   = own_req.instr;
                s_addr    = own_req.addr;
                s_wdata   = own_req.wdata;
                s_wstrb   = own_req.wstrb;
                own_ready = s_ready;
                own_rdata = s_rdata;

                if (s_ready) begin
                    state_nxt = IDLE;
                    last_nxt  = owner;
                end else if (!own_req.valid) begin
                    // Master abandoned the request: release without touching fairness.
                    state_nxt = IDLE;
                end else if (expired) begin
                    s_valid   = 1'b0;
                    own_ready = 1'b1;
                    own_rdata = ERR_RDATA;
                    to_hit    = 1'b1;
                    state_nxt = IDLE;
                    last_nxt  = owner;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    assign m0_ready = own_ready && (state == OWN0);
    assign m0_rdata = (state == OWN0) ? own_rdata : '0;
    assign m1_ready = own_ready && (state == OWN1);
    assign m1_rdata = (state == OWN1) ? own_rdata : '0;

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .resetn (resetn),
        .active (state != IDLE),
        .s_ready(s_ready),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timeout_err <= 1'b0;
        end else if (to_hit) begin
            timeout_err <= 1'b1;
        end
    end
`else
    logic unused_cfg;

    assign expired     = 1'b0;
    assign timeout_err = 1'b0;
    assign unused_cfg  = ^{ERR_RDATA, TIMEOUT_CYCLES, to_hit};
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (default build and MEM_ARB_TIMEOUT_EN).
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_valid, m0_instr, m1_valid, m1_instr;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid, s_instr, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  grant;
    logic        timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .TIMEOUT_CYCLES(4),
        .ERR_RDATA     (32'hDEAD_BEEF)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .m0_valid   (m0_valid),
        .m0_instr   (m0_instr),
        .m0_addr    (m0_addr),
        .m0_wdata   (m0_wdata),
        .m0_wstrb   (m0_wstrb),
        .m0_ready   (m0_ready),
        .m0_rdata   (m0_rdata),
        .m1_valid   (m1_valid),
        .m1_instr   (m1_instr),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_wstrb   (m1_wstrb),
        .m1_ready   (m1_ready),
        .m1_rdata   (m1_rdata),
        .s_valid    (s_valid),
        .s_instr    (s_instr),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_wstrb    (s_wstrb),
        .s_ready    (s_ready),
        .s_rdata    (s_rdata),
        .grant      (grant),
        .timeout_err(timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_tests++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks run 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    int n0, n1;
    logic [1:0] exp_grant;

    initial begin
        resetn   = 1'b0;
        m0_valid = 1'b0; m0_instr = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_valid = 1'b0; m1_instr = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        s_ready  = 1'b0; s_rdata  = '0;

        // Reset state
        settle();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_s_valid", 32'(s_valid), 32'h0);
        check("rst_m0_ready", 32'(m0_ready), 32'h0);
        check("rst_timeout_err", 32'(timeout_err), 32'h0);
        tick();
        tick();
        resetn = 1'b1;

        // Single master read
        m0_valid = 1'b1; m0_addr = 32'h0000_0010; m0_instr = 1'b1;
        settle();
        check("t1_idle_s_valid", 32'(s_valid), 32'h0);
        tick();
        check("t1_grant_own", 32'(grant), 32'h1);
        check("t1_s_valid", 32'(s_valid), 32'h1);
        check("t1_s_addr", s_addr, 32'h0000_0010);
        check("t1_s_instr", 32'(s_instr), 32'h1);
        check("t1_m0_ready_wait", 32'(m0_ready), 32'h0);
        tick();
        s_ready = 1'b1; s_rdata = 32'h1234_5678;
        settle();
        check("t1_m0_ready", 32'(m0_ready), 32'h1);
        check("t1_m0_rdata", m0_rdata, 32'h1234_5678);
        check("t1_m1_ready", 32'(m1_ready), 32'h0);
        check("t1_m1_rdata", m1_rdata, 32'h0);
        tick();
        m0_valid = 1'b0; m0_instr = 1'b0; s_ready = 1'b0; s_rdata = '0;
        settle();
        check("t1_grant_idle", 32'(grant), 32'h0);
        check("t1_m0_ready_after", 32'(m0_ready), 32'h0);

        // Simultaneous first requests after reset: m0 first, then m1
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        m0_valid = 1'b1; m1_valid = 1'b1; s_ready = 1'b1; s_rdata = 32'hAAAA_0000;
        tick();
        check("t2_grant_m0", 32'(grant), 32'h1);
        check("t2_m0_ready", 32'(m0_ready), 32'h1);
        check("t2_m1_ready_hold", 32'(m1_ready), 32'h0);
        tick();
        m0_valid = 1'b0;
        settle();
        check("t2_grant_bubble", 32'(grant), 32'h0);
        tick();
        check("t2_grant_m1", 32'(grant), 32'h2);
        check("t2_m1_ready", 32'(m1_ready), 32'h1);
        check("t2_m1_rdata", m1_rdata, 32'hAAAA_0000);
        check("t2_m0_ready", 32'(m0_ready), 32'h0);
        tick();
        m1_valid = 1'b0;

        // Continuous contention with a zero-wait slave
        m0_valid = 1'b1; m1_valid = 1'b1; s_ready = 1'b1;
        n0 = 0; n1 = 0;
        for (int i = 0; i < 32; i++) begin
            settle();
            case (i % 4)
                1:       exp_grant = 2'b01;
                3:       exp_grant = 2'b10;
                default: exp_grant = 2'b00;
            endcase
            check($sformatf("t3_grant_%0d", i), 32'(grant), 32'(exp_grant));
            if (m0_ready) n0++;
            if (m1_ready) n1++;
            tick();
        end
        check("t3_m0_count", 32'(n0), 32'd8);
        check("t3_m1_count", 32'(n1), 32'd8);
        m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;

        // Write pass-through from m1
        m0_addr = 32'hFFFF_0000; m0_wdata = 32'h1111_1111;
        m1_valid = 1'b1; m1_addr = 32'h0300_0000; m1_wdata = 32'hA5A5_A5A5; m1_wstrb = 4'b0011;
        s_rdata = 32'h5555_5555;
        tick();
        check("t4_grant", 32'(grant), 32'h2);
        check("t4_s_valid", 32'(s_valid), 32'h1);
        check("t4_s_addr", s_addr, 32'h0300_0000);
        check("t4_s_wdata", s_wdata, 32'hA5A5_A5A5);
        check("t4_s_wstrb", 32'(s_wstrb), 32'h3);
        check("t4_m0_rdata", m0_rdata, 32'h0);
        s_ready = 1'b1;
        settle();
        check("t4_m1_ready", 32'(m1_ready), 32'h1);
        check("t4_m0_ready", 32'(m0_ready), 32'h0);
        check("t4_m0_rdata_ready", m0_rdata, 32'h0);
        tick();
        m1_valid = 1'b0; m1_wstrb = '0; s_ready = 1'b0; s_rdata = '0;

        // Reset mid-transfer; first m0 completes so the tie would otherwise go to m1
        m0_valid = 1'b1;
        tick();
        s_ready = 1'b1;
        tick();
        m0_valid = 1'b0; s_ready = 1'b0;
        m0_valid = 1'b1;
        tick();
        check("t5_s_valid_before", 32'(s_valid), 32'h1);
        #1;
        resetn = 1'b0; s_ready = 1'b1;
        #1;
        check("t5_s_valid_async", 32'(s_valid), 32'h0);
        check("t5_m0_ready", 32'(m0_ready), 32'h0);
        check("t5_grant", 32'(grant), 32'h0);
        tick();
        s_ready = 1'b0; resetn = 1'b1; m1_valid = 1'b1;
        tick();
        check("t5_tie_after_reset", 32'(grant), 32'h1);
        s_ready = 1'b1;
        tick();
        m0_valid = 1'b0; s_ready = 1'b0;

        // Abandoned request releases the bus without changing fairness
        tick();
        check("t6_grant_m1", 32'(grant), 32'h2);
        m1_valid = 1'b0;
        settle();
        check("t6_m1_ready", 32'(m1_ready), 32'h0);
        tick();
        check("t6_grant_idle", 32'(grant), 32'h0);
        m0_valid = 1'b1; m1_valid = 1'b1;
        tick();
        check("t6_tie_keeps_last", 32'(grant), 32'h2);
        s_ready = 1'b1;
        tick();
        m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;

`ifdef MEM_ARB_TIMEOUT_EN
        // Watchdog with TIMEOUT_CYCLES = 4
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        m0_valid = 1'b1;
        tick();
        check("to_c1_ready", 32'(m0_ready), 32'h0);
        tick();
        tick();
        check("to_c3_ready", 32'(m0_ready), 32'h0);
        tick();
        check("to_c4_ready", 32'(m0_ready), 32'h1);
        check("to_c4_rdata", m0_rdata, 32'hDEAD_BEEF);
        check("to_c4_s_valid", 32'(s_valid), 32'h0);
        tick();
        m0_valid = 1'b0;
        settle();
        check("to_err_set", 32'(timeout_err), 32'h1);
        check("to_grant_idle", 32'(grant), 32'h0);
        m1_valid = 1'b1; s_ready = 1'b1; s_rdata = 32'h0BAD_F00D;
        tick();
        check("to_m1_ready", 32'(m1_ready), 32'h1);
        check("to_m1_rdata", m1_rdata, 32'h0BAD_F00D);
        tick();
        m1_valid = 1'b0; s_ready = 1'b0;
        settle();
        check("to_err_sticky", 32'(timeout_err), 32'h1);
`else
        check("no_timeout_err", 32'(timeout_err), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
